// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine host.
package sme_pkg;

    localparam int unsigned S_MAX = 32;
    localparam int unsigned P_MAX = 8;
    localparam int unsigned TMO   = 255;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StSendS,
        StSendP,
        StWait,
        StResult
    } sme_state_e;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: one write port and a registered indexed read that yields 0 when not reading.
module sme_char_buf #(
    parameter int unsigned Depth = 8,
    parameter int unsigned IdxW  = $clog2(Depth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_idx,
    input  logic [7:0]      wr_data,
    input  logic            rd_en,
    input  logic [IdxW-1:0] rd_idx,
    output logic [7:0]      rd_data
);

    logic [7:0] mem_q [Depth];
    logic [7:0] rd_data_q, rd_data_d;

    // Read data is forced to 0 when idle so the host can OR both buffers onto chardata.
    always_comb begin
        rd_data_d = 8'h00;
        if (rd_en) rd_data_d = mem_q[rd_idx];
    end

    // Storage needs no reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= 8'h00;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sme_host.sv
// Host sequencer: loads string/pattern buffers, streams them to the engine and collects the result.
module sme_host #(
    parameter int unsigned S_MAX = sme_pkg::S_MAX,
    parameter int unsigned P_MAX = sme_pkg::P_MAX,
    parameter int unsigned TMO   = sme_pkg::TMO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_en,
    input  logic       ld_sel,
    input  logic [7:0] ld_data,
    input  logic       start,
    input  logic       keep_string,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    output logic       busy,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       err
);
    import sme_pkg::*;

    localparam int unsigned SIdxW = $clog2(S_MAX);
    localparam int unsigned PIdxW = $clog2(P_MAX);

    sme_state_e state_q, state_d;
    logic [5:0] s_len_q, s_len_d, s_idx_q, s_idx_d, s_ld_idx;
    logic [3:0] p_len_q, p_len_d, p_idx_q, p_idx_d;
    logic [7:0] tmo_q, tmo_d;
    logic       s_restart_q, s_restart_d;
    logic       isstring_q, isstring_d, ispattern_q, ispattern_d, busy_q, busy_d;
    logic       res_valid_q, res_valid_d, res_match_q, res_match_d, err_q, err_d;
    logic [4:0] res_index_q, res_index_d;

    logic             s_wr_en, p_wr_en, s_rd_en, p_rd_en;
    logic [SIdxW-1:0] s_wr_idx, s_rd_idx;
    logic [PIdxW-1:0] p_wr_idx, p_rd_idx;
    logic [7:0]       s_rd_data, p_rd_data;

    // Next-state: buffer loading in IDLE plus the job sequencer.
    always_comb begin
        state_d     = state_q;
        s_len_d     = s_len_q;
        p_len_d     = p_len_q;
        s_idx_d     = s_idx_q;
        p_idx_d     = p_idx_q;
        tmo_d       = tmo_q;
        s_restart_d = s_restart_q;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        res_valid_d = 1'b0;
        err_d       = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        s_wr_en     = 1'b0;
        p_wr_en     = 1'b0;
        s_wr_idx    = '0;
        p_wr_idx    = '0;
        s_rd_en     = 1'b0;
        p_rd_en     = 1'b0;
        s_rd_idx    = '0;
        p_rd_idx    = '0;
        // First string write after a job overwrites from index 0.
        s_ld_idx    = s_restart_q ? 6'd0 : s_len_q;

        if (state_q == StIdle && ld_en) begin
            if (!ld_sel) begin
                if (s_ld_idx < 6'(S_MAX)) begin
                    s_wr_en     = 1'b1;
                    s_wr_idx    = s_ld_idx[SIdxW-1:0];
                    s_len_d     = s_ld_idx + 6'd1;
                    s_restart_d = 1'b0;
                end
            end else if (p_len_q < 4'(P_MAX)) begin
                p_wr_en  = 1'b1;
                p_wr_idx = p_len_q[PIdxW-1:0];
                p_len_d  = p_len_q + 4'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (p_len_q == 4'd0 || (!keep_string && s_len_q == 6'd0)) begin
                        err_d = 1'b1;
                    end else if (!keep_string) begin
                        state_d    = StSendS;
                        isstring_d = 1'b1;
                        s_rd_en    = 1'b1;
                        s_idx_d    = 6'd1;
                    end else begin
                        state_d     = StSendP;
                        ispattern_d = 1'b1;
                        p_rd_en     = 1'b1;
                        p_idx_d     = 4'd1;
                    end
                end
            end
            StSendS: begin
                if (s_idx_q == s_len_q) begin
                    state_d     = StSendP;
                    ispattern_d = 1'b1;
                    p_rd_en     = 1'b1;
                    p_idx_d     = 4'd1;
                end else begin
                    isstring_d = 1'b1;
                    s_rd_en    = 1'b1;
                    s_rd_idx   = s_idx_q[SIdxW-1:0];
                    s_idx_d    = s_idx_q + 6'd1;
                end
            end
            StSendP: begin
                if (p_idx_q == p_len_q) begin
                    state_d = StWait;
                    tmo_d   = 8'd0;
                end else begin
                    ispattern_d = 1'b1;
                    p_rd_en     = 1'b1;
                    p_rd_idx    = p_idx_q[PIdxW-1:0];
                    p_idx_d     = p_idx_q + 4'd1;
                end
            end
            StWait: begin
                tmo_d = tmo_q + 8'd1;
                if (valid) begin
                    state_d     = StResult;
                    res_valid_d = 1'b1;
                    res_match_d = match;
                    res_index_d = match_index;
                end else if (tmo_d == 8'(TMO)) begin
                    state_d     = StResult;
                    res_valid_d = 1'b1;
                    res_match_d = 1'b0;
                    res_index_d = 5'd0;
                    err_d       = 1'b1;
                end
            end
            StResult: begin
                state_d     = StIdle;
                p_len_d     = 4'd0;
                s_restart_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            s_len_q     <= 6'd0;
            p_len_q     <= 4'd0;
            s_idx_q     <= 6'd0;
            p_idx_q     <= 4'd0;
            tmo_q       <= 8'd0;
            s_restart_q <= 1'b0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_len_q     <= s_len_d;
            p_len_q     <= p_len_d;
            s_idx_q     <= s_idx_d;
            p_idx_q     <= p_idx_d;
            tmo_q       <= tmo_d;
            s_restart_q <= s_restart_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            err_q       <= err_d;
        end
    end

    sme_char_buf #(.Depth(S_MAX), .IdxW(SIdxW)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s_wr_en),
        .wr_idx  (s_wr_idx),
        .wr_data (ld_data),
        .rd_en   (s_rd_en),
        .rd_idx  (s_rd_idx),
        .rd_data (s_rd_data)
    );

    sme_char_buf #(.Depth(P_MAX), .IdxW(PIdxW)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (p_wr_en),
        .wr_idx  (p_wr_idx),
        .wr_data (ld_data),
        .rd_en   (p_rd_en),
        .rd_idx  (p_rd_idx),
        .rd_data (p_rd_data)
    );

    // Both read ports are zero when idle, so chardata is 0 unless one buffer is streaming.
    assign chardata  = s_rd_data | p_rd_data;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sme_host.sv
// Directed bench for sme_host with a hand-driven engine model.
module tb_sme_host;
    import sme_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic       clk, reset;
    logic       ld_en, ld_sel, start, keep_string, valid, match;
    logic [7:0] ld_data;
    logic [4:0] match_index;
    logic [7:0] chardata;
    logic       isstring, ispattern, busy, res_valid, res_match, err;
    logic [4:0] res_index;

    int n_checks = 0;
    int n_pass   = 0;

    sme_host u_dut (
        .clk         (clk),
        .reset       (reset),
        .ld_en       (ld_en),
        .ld_sel      (ld_sel),
        .ld_data     (ld_data),
        .start       (start),
        .keep_string (keep_string),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_match   (res_match),
        .res_index   (res_index),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input bq_t d);
        foreach (d[i]) begin
            ld_en   = 1'b1;
            ld_sel  = sel;
            ld_data = d[i];
            tick();
        end
        ld_en   = 1'b0;
        ld_data = 8'h00;
    endtask

    // Start a job, check the character stream, then play the engine.
    // vdelay < 0 means the engine never answers.
    task automatic run_job(input logic keep, input bq_t es, input bq_t ep, input int vdelay,
                           input logic m, input logic [4:0] mi, input logic exp_m,
                           input logic [4:0] exp_i, input logic exp_err, input int exp_cyc);
        int cyc;
        start       = 1'b1;
        keep_string = keep;
        tick();
        start       = 1'b0;
        keep_string = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        foreach (es[i]) begin
            check("s_flags", {30'd0, isstring, ispattern}, 32'd2);
            check("s_char", {24'd0, chardata}, {24'd0, es[i]});
            tick();
        end
        foreach (ep[i]) begin
            check("p_flags", {30'd0, isstring, ispattern}, 32'd1);
            check("p_char", {24'd0, chardata}, {24'd0, ep[i]});
            tick();
        end
        check("wait_idle", {22'd0, isstring, ispattern, chardata}, 32'd0);
        cyc = 0;
        while (!res_valid && cyc < 400) begin
            if (cyc == vdelay) begin
                valid       = 1'b1;
                match       = m;
                match_index = mi;
            end
            tick();
            valid       = 1'b0;
            match       = 1'b0;
            match_index = 5'd0;
            cyc++;
        end
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("wait_cycles", cyc, exp_cyc);
        check("res_match", {31'd0, res_match}, {31'd0, exp_m});
        check("res_index", {27'd0, res_index}, {27'd0, exp_i});
        check("res_err", {31'd0, err}, {31'd0, exp_err});
        tick();
        check("post_res", {29'd0, res_valid, busy, err}, 32'd0);
        check("res_hold", {26'd0, res_match, res_index}, {26'd0, exp_m, exp_i});
    endtask

    initial begin
        bq_t s_ab, p_b, p_ca, p_zz, s33, p9, s_exp, p_exp, s_xyz, p_q, empty_q;
        logic seen;
        reset = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_data = 8'h00; start = 1'b0;
        keep_string = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
        s_ab = '{8'h61, 8'h62};
        p_b  = '{8'h62};
        p_ca = '{CH_CARET, 8'h61};
        p_zz = '{8'h7A, 8'h7A};
        s_xyz = '{8'h78, 8'h79, 8'h7A};
        p_q  = '{8'h71};
        for (int i = 0; i < 33; i++) s33.push_back(8'(8'h41 + i));
        for (int i = 0; i < 9; i++) p9.push_back(8'(8'h30 + i));
        for (int i = 0; i < 32; i++) s_exp.push_back(s33[i]);
        for (int i = 0; i < 8; i++) p_exp.push_back(p9[i]);

        tick();
        tick();
        check("rst_outputs", {22'd0, isstring, ispattern, chardata}, 32'd0);
        check("rst_status", {24'd0, busy, res_valid, res_match, res_index}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        tick();

        // "ab" against "b": two string chars then one pattern char.
        load(1'b0, s_ab);
        load(1'b1, p_b);
        run_job(1'b0, s_ab, p_b, 3, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 4);

        // valid outside WAIT does nothing.
        valid = 1'b1; match = 1'b0; match_index = 5'd7;
        tick();
        valid = 1'b0; match_index = 5'd0;
        check("idle_valid_ignored", {25'd0, res_valid, res_match, res_index}, {25'd0, 1'b0, 1'b1, 5'd1});
        tick();

        // Reuse held string, pattern only.
        load(1'b1, p_ca);
        run_job(1'b1, empty_q, p_ca, 0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1);

        // Pattern length cleared by the previous job: start must be rejected.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reject_err", {31'd0, err}, 32'd1);
        check("reject_idle", {21'd0, busy, isstring, ispattern, chardata}, 32'd0);
        tick();
        check("reject_err_pulse", {29'd0, err, busy, isstring}, 32'd0);

        // Engine never answers.
        load(1'b1, p_zz);
        run_job(1'b1, empty_q, p_zz, -1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 255);

        // Overflowing loads are truncated to buffer depth.
        load(1'b0, s33);
        load(1'b1, p9);
        run_job(1'b0, s_exp, p_exp, 2, 1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 3);

        // Reset in the middle of the string phase.
        load(1'b0, s_xyz);
        load(1'b1, p_q);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_sending", {30'd0, isstring, busy}, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_drop", {21'd0, isstring, ispattern, busy, chardata}, 32'd0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid = (i == 3);
            tick();
            valid = 1'b0;
            if (res_valid || busy || isstring || ispattern) seen = 1'b1;
        end
        check("no_result_after_rst", {31'd0, seen}, 32'd0);
        check("rst_res_cleared", {26'd0, res_match, res_index}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
